// File: rtl/mw_alu_sequencer.sv
// Purpose: feeds a wide operand pair to a 32-bit combinational ALU one word per cycle, LS word first, chaining carry.
// Latency: accept at edge T, WORDS RUN cycles, done pulses in cycle T+WORDS+1, ready again the cycle after.
// Backpressure: start is taken only while ready=1; requests in RUN/DONE are dropped, never queued.
// Ports:
//   clk, reset (sync, active-high)          - clocking
//   start/ready, op_in, cin_in, a_in, b_in  - request side, sampled on accept
//   result_out, cout_out, done              - completion side, held until the next accept
//   alu_a/alu_b/alu_op/alu_cin -> ALU, alu_result/alu_cout <- ALU (combinational loop through the ALU)
module mw_alu_sequencer #(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  ready,
   input  logic [2:0]            op_in,
   input  logic                  cin_in,
   input  logic [32*WORDS-1:0]   a_in,
   input  logic [32*WORDS-1:0]   b_in,
   output logic [32*WORDS-1:0]   result_out,
   output logic                  cout_out,
   output logic                  done,
   output logic [31:0]           alu_a,
   output logic [31:0]           alu_b,
   output logic [2:0]            alu_op,
   output logic                  alu_cin,
   input  logic [31:0]           alu_result,
   input  logic                  alu_cout
);

   localparam int IW = $clog2(WORDS);
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]            state;
   logic [32*WORDS-1:0]   a_reg;
   logic [32*WORDS-1:0]   b_reg;
   logic [2:0]            op_reg;
   logic                  carry;
   logic [IW-1:0]         idx;
   logic [32*WORDS-1:0]   res_reg;
   logic                  cout_reg;

   assign ready      = (state == S_IDLE);
   assign done       = (state == S_DONE);
   assign result_out = res_reg;
   assign cout_out   = cout_reg;

   // The ALU sees the word selected by idx; its outputs come straight back
   // this same cycle and are captured on the next edge.
   assign alu_a   = a_reg[32*idx +: 32];
   assign alu_b   = b_reg[32*idx +: 32];
   assign alu_op  = op_reg;
   assign alu_cin = carry;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         idx      <= '0;
         carry    <= 1'b0;
         a_reg    <= '0;
         b_reg    <= '0;
         op_reg   <= '0;
         res_reg  <= '0;
         cout_reg <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // res_reg/cout_reg are deliberately left alone here; they are
               // overwritten word by word while RUN progresses.
               if (start) begin
                  a_reg  <= a_in;
                  b_reg  <= b_in;
                  op_reg <= op_in;
                  carry  <= cin_in;
                  idx    <= '0;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               res_reg[32*idx +: 32] <= alu_result;
               carry                 <= alu_cout;
               if (idx == LAST) begin
                  cout_reg <= alu_cout;
                  idx      <= '0;
                  state    <= S_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mw_alu_sequencer.sv
// Purpose: self-checking bench for mw_alu_sequencer (WORDS=4 main instance, WORDS=2 ripple instance).
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_mw_alu_sequencer;
   localparam int W = 4;
   localparam int N = 32*W;

   logic          clk = 1'b0;
   logic          reset = 1'b1;

   // WORDS=4 instance
   logic          start = 1'b0;
   logic          ready;
   logic [2:0]    op_in = 3'd0;
   logic          cin_in = 1'b0;
   logic [N-1:0]  a_in = '0;
   logic [N-1:0]  b_in = '0;
   logic [N-1:0]  result_out;
   logic          cout_out;
   logic          done;
   logic [31:0]   alu_a, alu_b, alu_result;
   logic [2:0]    alu_op;
   logic          alu_cin, alu_cout;

   // WORDS=2 instance
   logic          s2_start = 1'b0;
   logic          s2_ready;
   logic [2:0]    s2_op_in = 3'd0;
   logic          s2_cin_in = 1'b0;
   logic [63:0]   s2_a_in = '0;
   logic [63:0]   s2_b_in = '0;
   logic [63:0]   s2_result_out;
   logic          s2_cout_out;
   logic          s2_done;
   logic [31:0]   s2_alu_a, s2_alu_b, s2_alu_result;
   logic [2:0]    s2_alu_op;
   logic          s2_alu_cin, s2_alu_cout;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // ALU stub: plain add with carry, op ignored.
   assign {alu_cout, alu_result}       = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
   assign {s2_alu_cout, s2_alu_result} = {1'b0, s2_alu_a} + {1'b0, s2_alu_b} + {32'd0, s2_alu_cin};

   mw_alu_sequencer #(.WORDS(W)) dut (
      .clk(clk), .reset(reset), .start(start), .ready(ready),
      .op_in(op_in), .cin_in(cin_in), .a_in(a_in), .b_in(b_in),
      .result_out(result_out), .cout_out(cout_out), .done(done),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
      .alu_result(alu_result), .alu_cout(alu_cout)
   );

   mw_alu_sequencer #(.WORDS(2)) dut2 (
      .clk(clk), .reset(reset), .start(s2_start), .ready(s2_ready),
      .op_in(s2_op_in), .cin_in(s2_cin_in), .a_in(s2_a_in), .b_in(s2_b_in),
      .result_out(s2_result_out), .cout_out(s2_cout_out), .done(s2_done),
      .alu_a(s2_alu_a), .alu_b(s2_alu_b), .alu_op(s2_alu_op), .alu_cin(s2_alu_cin),
      .alu_result(s2_alu_result), .alu_cout(s2_alu_cout)
   );

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model for the WORDS=4 instance. An accepted request is kept as
   // its operands plus the full-width sum; everything the DUT should show is
   // derived from the number of cycles elapsed since the accept.
   int           n_neg = 0;
   int           acc_n = 0;
   bit           acc_v = 1'b0;
   bit           m_on  = 1'b0;
   logic [N-1:0] m_a, m_b, new_res;
   logic [N-1:0] held_res = '0;
   logic [2:0]   m_op;
   logic         m_cin, new_cout;
   logic         held_cout = 1'b0;

   always @(negedge clk) begin
      int           k;
      int           w;
      bit           busy;
      logic [N-1:0] exp_res;
      logic [N:0]   mask;
      logic [N:0]   part;
      n_neg++;
      k    = n_neg - acc_n;
      busy = acc_v && (k >= 1) && (k <= W + 1);
      if (m_on) begin
         chk("ready", 512'(ready), 512'(!busy));
         chk("done",  512'(done),  512'(busy && k == W + 1));
         if (busy && k <= W) begin
            w    = k - 1;
            mask = ((N+1)'(1) << (32*w)) - (N+1)'(1);
            part = ({1'b0, m_a} & mask) + ({1'b0, m_b} & mask) + (N+1)'(m_cin);
            chk("alu_a",   512'(alu_a),   512'(m_a[32*w +: 32]));
            chk("alu_b",   512'(alu_b),   512'(m_b[32*w +: 32]));
            chk("alu_op",  512'(alu_op),  512'(m_op));
            chk("alu_cin", 512'(alu_cin), 512'(part[32*w]));
            for (int j = 0; j < W; j++)
               exp_res[32*j +: 32] = (j < w) ? new_res[32*j +: 32] : held_res[32*j +: 32];
            chk("partial_result", 512'(result_out), 512'(exp_res));
            chk("run_cout", 512'(cout_out), 512'(held_cout));
         end else begin
            if (busy && k == W + 1) begin
               held_res  = new_res;
               held_cout = new_cout;
            end
            chk("result", 512'(result_out), 512'(held_res));
            chk("cout",   512'(cout_out),   512'(held_cout));
         end
      end
      if (reset) begin
         acc_v     = 1'b0;
         held_res  = '0;
         held_cout = 1'b0;
         m_on      = 1'b1;
      end else if (m_on && start && !busy) begin
         acc_v = 1'b1;
         acc_n = n_neg;
         m_a   = a_in;
         m_b   = b_in;
         m_op  = op_in;
         m_cin = cin_in;
         {new_cout, new_res} = {1'b0, a_in} + {1'b0, b_in} + (N+1)'(cin_in);
      end
   end

   task automatic wait_done(output int steps);
      steps = 0;
      while (!done && steps < 40) begin
         step();
         steps++;
      end
      chk("done_seen", 512'(done), 512'(1));
   endtask

   initial begin
      int s;
      int cnt;
      int g;
      logic [N-1:0] cap;

      // reset and idle
      step();
      step();
      reset = 1'b0;
      chk("rst_ready",  512'(ready),      512'(1));
      chk("rst_done",   512'(done),       512'(0));
      chk("rst_result", 512'(result_out), 512'(0));
      chk("rst_cout",   512'(cout_out),   512'(0));
      for (int i = 0; i < 10; i++) step();
      chk("idle_result", 512'(result_out), 512'(0));
      chk("idle_ready",  512'(ready),      512'(1));

      // carry ripple on the 2-word instance
      s2_a_in   = 64'h00000000_FFFFFFFF;
      s2_b_in   = 64'h00000000_00000001;
      s2_cin_in = 1'b0;
      s2_op_in  = 3'b101;
      s2_start  = 1'b1;
      step();
      s2_start  = 1'b0;
      chk("w2_op0",  512'(s2_alu_op),  512'(3'b101));
      chk("w2_cin0", 512'(s2_alu_cin), 512'(0));
      chk("w2_a0",   512'(s2_alu_a),   512'(32'hFFFFFFFF));
      chk("w2_done0", 512'(s2_done),   512'(0));
      step();
      chk("w2_op1",  512'(s2_alu_op),  512'(3'b101));
      chk("w2_cin1", 512'(s2_alu_cin), 512'(1));
      chk("w2_done1", 512'(s2_done),   512'(0));
      step();
      chk("w2_done", 512'(s2_done),       512'(1));
      chk("w2_res",  512'(s2_result_out), 512'(64'h00000001_00000000));
      chk("w2_cout", 512'(s2_cout_out),   512'(0));
      step();
      chk("w2_done_after",  512'(s2_done),  512'(0));
      chk("w2_ready_after", 512'(s2_ready), 512'(1));

      // full carry-out
      a_in = '1; b_in = '0; cin_in = 1'b1; op_in = 3'd2; start = 1'b1;
      step();
      start = 1'b0;
      wait_done(s);
      chk("full_latency", 512'(s), 512'(W));
      chk("full_result", 512'(result_out), 512'(0));
      chk("full_cout",   512'(cout_out),   512'(1));

      // busy rejection
      step();
      a_in = N'(5); b_in = N'(7); cin_in = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step();
      a_in = N'(1); b_in = N'(1); start = 1'b1;
      step();
      start = 1'b0;
      cnt = 0;
      cap = '0;
      for (int i = 0; i < 12; i++) begin
         if (done) begin
            cnt++;
            cap = result_out;
         end
         step();
      end
      chk("busy_dones",  512'(cnt), 512'(1));
      chk("busy_result", 512'(cap), 512'(12));

      // reset in the second RUN cycle
      a_in = N'(99); b_in = N'(1); start = 1'b1;
      step();
      start = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_ready",  512'(ready),      512'(1));
      chk("mid_rst_result", 512'(result_out), 512'(0));
      chk("mid_rst_done",   512'(done),       512'(0));
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (done) cnt++;
         step();
      end
      chk("mid_rst_no_done", 512'(cnt), 512'(0));
      a_in = N'(3); b_in = N'(4); cin_in = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      wait_done(s);
      chk("after_rst_result", 512'(result_out), 512'(7));
      step();

      // back-to-back with start held high
      a_in = N'(10); b_in = N'(20); cin_in = 1'b0; start = 1'b1;
      step();
      a_in = N'(100); b_in = N'(200);
      wait_done(s);
      chk("b2b_first", 512'(result_out), 512'(30));
      step();
      g = 1;
      while (!done && g < 40) begin
         step();
         g++;
      end
      start = 1'b0;
      chk("b2b_gap",    512'(g),          512'(W + 2));
      chk("b2b_second", 512'(result_out), 512'(300));

      // randomized traffic, model checks every cycle
      for (int c = 0; c < 400; c++) begin
         start  = ($urandom_range(0, 2) == 0);
         reset  = ($urandom_range(0, 79) == 0);
         op_in  = 3'($urandom);
         cin_in = 1'($urandom);
         for (int j = 0; j < W; j++) begin
            a_in[32*j +: 32] = $urandom;
            b_in[32*j +: 32] = $urandom;
         end
         if ($urandom_range(0, 3) == 0) a_in = '1;
         if ($urandom_range(0, 3) == 0) b_in = '0;
         step();
      end
      reset = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 10; i++) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
